// File: rtl/ttt_pkg.sv
// Shared types for the tic-tac-toe controller: cell codes, board layout, FSM states.
// Combinational helpers only; no latency, no flow control.
package ttt_pkg;

  typedef logic [1:0] cell_t;
  typedef cell_t [3:1][3:1] board_t;

  localparam cell_t EMPTY = 2'd0;
  localparam cell_t P1    = 2'd1;
  localparam cell_t P2    = 2'd2;
  localparam cell_t DRAW  = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_MOVE,
    CHECK,
    SWITCH,
    DONE
  } state_t;

  // Row/col 0 never matches, so an illegal coordinate reads back as EMPTY.
  function automatic cell_t cell_at(board_t b, logic [1:0] row, logic [1:0] col);
    cell_t c;
    c = EMPTY;
    for (int r = 1; r <= 3; r++) begin
      for (int k = 1; k <= 3; k++) begin
        if (2'(r) == row && 2'(k) == col) c = b[r][k];
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/turn_timer.sv
// Per-turn countdown: load beats enable, count drops by one per enabled cycle, expire on the
// last enabled cycle (count==1). Registered count, one-cycle load latency, no backpressure.
module turn_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             expire
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= count - 1'b1;
    end
  end

  assign expire = en && (count == CNT_W'(1));

endmodule

// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe game controller: board register, turn order, move validation, turn timeout.
// Move sampled at E -> accept/CHECK at E+1 -> DONE/SWITCH at E+2; no backpressure, moves outside WAIT_MOVE dropped.
module ttt_game_ctrl
  import ttt_pkg::*;
#(
  parameter  int TURN_TIMEOUT = 750_000_000,
  localparam int CNT_W        = $clog2(TURN_TIMEOUT + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  move_valid,
  input  logic [1:0]            move_row,
  input  logic [1:0]            move_col,
  input  logic [1:0]            winner,
  output logic [3:1][3:1][1:0]  board,
  output logic                  en_check,
  output logic [1:0]            cur_player,
  output logic                  move_accept,
  output logic                  move_reject,
  output logic [CNT_W-1:0]      timer_left,
  output logic                  game_over,
  output logic [1:0]            result
);

  state_t     state, state_d;
  board_t     board_q, board_d;
  cell_t      player_q, player_d;
  logic [1:0] result_q, result_d;
  logic       accept_q, accept_d;
  logic       reject_q, reject_d;
  logic       timer_load, timer_en, timer_expire;
  logic       move_legal;

  turn_timer #(.CNT_W(CNT_W)) u_turn_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .en       (timer_en),
    .load_val (CNT_W'(TURN_TIMEOUT)),
    .count    (timer_left),
    .expire   (timer_expire)
  );

  assign move_legal = (move_row != 2'd0) && (move_col != 2'd0) &&
                      (cell_at(board_q, move_row, move_col) == EMPTY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      board_q  <= '0;
      player_q <= P1;
      result_q <= EMPTY;
      accept_q <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      state    <= state_d;
      board_q  <= board_d;
      player_q <= player_d;
      result_q <= result_d;
      accept_q <= accept_d;
      reject_q <= reject_d;
    end
  end

  always_comb begin
    state_d    = state;
    board_d    = board_q;
    player_d   = player_q;
    result_d   = result_q;
    accept_d   = 1'b0;
    reject_d   = 1'b0;
    timer_load = 1'b0;
    timer_en   = (state == WAIT_MOVE);

    // start restarts from any state and outranks a same-cycle move.
    if (start) begin
      state_d    = WAIT_MOVE;
      board_d    = '0;
      player_d   = P1;
      result_d   = EMPTY;
      timer_load = 1'b1;
    end else begin
      unique case (state)
        IDLE: ;
        WAIT_MOVE: begin
          if (move_valid && move_legal) begin
            for (int r = 1; r <= 3; r++) begin
              for (int k = 1; k <= 3; k++) begin
                if (2'(r) == move_row && 2'(k) == move_col) board_d[r][k] = player_q;
              end
            end
            accept_d = 1'b1;
            state_d  = CHECK;
          end else begin
            reject_d = move_valid;
            if (timer_expire) state_d = SWITCH;
          end
        end
        CHECK: begin
          if (winner != EMPTY) begin
            result_d = winner;
            state_d  = DONE;
          end else begin
            state_d = SWITCH;
          end
        end
        SWITCH: begin
          player_d   = (player_q == P1) ? P2 : P1;
          timer_load = 1'b1;
          state_d    = WAIT_MOVE;
        end
        DONE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  assign board       = board_q;
  assign cur_player  = player_q;
  assign result      = result_q;
  assign move_accept = accept_q;
  assign move_reject = reject_q;
  assign en_check    = (state == CHECK);
  assign game_over   = (state == DONE);

endmodule
